// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// FSM state encoding, default address/data widths and the hard-wired zero register.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_mc_fifo.sv
// Small synchronous FIFO holding multi-cycle results ({dest, data}) until a
// write-port slot is free. DEPTH must be a power of two so the pointers wrap
// naturally. Push is ignored when full and pop is ignored when empty.
module wb_mc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The WB stage has priority; multi-cycle
// results queue in wb_mc_fifo and drain into idle slots. A starvation counter
// forces a one-cycle pipeline stall so a queued result always retires.
// Optional performance counters are enabled with the macro WB_PERF_CNT_EN.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RegWrite,
  input  logic          MemToReg,
  input  logic [AW-1:0] writeReg,
  input  logic [DW-1:0] readData,
  input  logic [DW-1:0] ALUresult,
  output logic          pipe_stall,
  input  logic          mc_valid,
  output logic          mc_ready,
  input  logic [AW-1:0] mc_dest,
  input  logic [DW-1:0] mc_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          mc_pending
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_force_cnt,
  output logic [31:0]   perf_mc_full_cnt,
  output logic [31:0]   perf_wb_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e     state_q, state_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           rf_we_q, rf_we_d;
  logic [AW-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]  rf_wdata_q, rf_wdata_d;

  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count, count_nxt;
  logic [AW+DW-1:0] fifo_rdata;
  logic [AW-1:0]  head_dest;
  logic [DW-1:0]  head_data;
  logic           push, pop, grant, wb_win;
  logic [AW-1:0]  g_addr;
  logic [DW-1:0]  g_data;

  assign {head_dest, head_data} = fifo_rdata;

  // All handshake outputs come from registered state only.
  assign pipe_stall = (state_q == FORCE);
  assign mc_ready   = !fifo_full;
  assign mc_pending = !fifo_empty;
  assign push       = mc_valid && !fifo_full;

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  wb_mc_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({mc_dest, mc_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Port grant: forced slot, then WB stage, then FIFO head; writes to $0 are suppressed.
  always_comb begin
    grant  = 1'b0;
    pop    = 1'b0;
    wb_win = 1'b0;
    g_addr = '0;
    g_data = '0;
    if (state_q == FORCE) begin
      grant  = 1'b1;
      pop    = 1'b1;
      g_addr = head_dest;
      g_data = head_data;
    end else if (RegWrite) begin
      grant  = 1'b1;
      wb_win = 1'b1;
      g_addr = writeReg;
      g_data = MemToReg ? readData : ALUresult;
    end else if (!fifo_empty) begin
      grant  = 1'b1;
      pop    = 1'b1;
      g_addr = head_dest;
      g_data = head_data;
    end
    rf_we_d    = grant && (g_addr != AW'(REG_ZERO));
    rf_waddr_d = rf_we_d ? g_addr : '0;
    rf_wdata_d = rf_we_d ? g_data : '0;
    count_nxt  = fifo_count + CW'(push) - CW'(pop);
  end

  // Starvation counter and FSM next-state.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if ((state_q == DRAIN) && wb_win && (starve_q < SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (push) state_d = DRAIN;
      DRAIN: begin
        if (starve_d == SW'(STARVE_LIMIT)) state_d = FORCE;
        else if (count_nxt == '0)          state_d = IDLE;
      end
      FORCE:   state_d = (count_nxt != '0) ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, starvation counter and registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

`ifdef WB_PERF_CNT_EN
  // Free-running event counters; they wrap on overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_force_cnt   <= '0;
      perf_mc_full_cnt <= '0;
      perf_wb_cnt      <= '0;
    end else begin
      if (state_q == FORCE)       perf_force_cnt   <= perf_force_cnt + 32'd1;
      if (mc_valid && fifo_full)  perf_mc_full_cnt <= perf_mc_full_cnt + 32'd1;
      if (rf_we_q)                perf_wb_cnt      <= perf_wb_cnt + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk;
  logic          rst_n;
  logic          RegWrite, MemToReg;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] readData, ALUresult;
  logic          pipe_stall;
  logic          mc_valid, mc_ready;
  logic [AW-1:0] mc_dest;
  logic [DW-1:0] mc_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          mc_pending;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [AW+DW-1:0] mq[$];
  int               m_streak;
  bit               m_force;
  bit               m_rst;
  logic             exp_we;
  logic [AW-1:0]    exp_addr;
  logic [DW-1:0]    exp_data;

  wb_port_arbiter #(
    .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .writeReg(writeReg),
    .readData(readData), .ALUresult(ALUresult),
    .pipe_stall(pipe_stall),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_dest(mc_dest), .mc_data(mc_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mc_pending(mc_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock edge of the reference model, evaluated from the inputs about to be sampled.
  task automatic model_edge();
    logic [AW+DW-1:0] head;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    bit popped, wbw, nonempty, do_push;
    if (!rst_n) begin
      mq.delete();
      m_streak = 0;
      m_force  = 0;
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      m_rst    = 1;
      return;
    end
    m_rst    = 0;
    nonempty = (mq.size() > 0);
    do_push  = mc_valid && (mq.size() < DEPTH);
    popped   = 0;
    wbw      = 0;
    waddr    = '0;
    wdata    = '0;
    if (m_force || (!RegWrite && nonempty)) begin
      head   = mq.pop_front();
      popped = 1;
      waddr  = head[AW+DW-1:DW];
      wdata  = head[DW-1:0];
    end else if (RegWrite) begin
      wbw   = 1;
      waddr = writeReg;
      wdata = MemToReg ? readData : ALUresult;
    end
    exp_we   = (popped || wbw) && (waddr != 0);
    exp_addr = waddr;
    exp_data = wdata;
    if (do_push) mq.push_back({mc_dest, mc_data});
    if (popped || !nonempty)       m_streak = 0;
    else if (wbw && m_streak < LIMIT) m_streak++;
    m_force = (m_streak == LIMIT);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("rf_we", 32'(rf_we), 32'(exp_we));
    if (exp_we || m_rst) begin
      chk("rf_waddr", 32'(rf_waddr), m_rst ? 32'd0 : 32'(exp_addr));
      chk("rf_wdata", rf_wdata, m_rst ? 32'd0 : exp_data);
    end
    chk("pipe_stall", 32'(pipe_stall), 32'(m_force));
    chk("mc_ready",   32'(mc_ready),   32'(mq.size() < DEPTH));
    chk("mc_pending", 32'(mc_pending), 32'(mq.size() > 0));
  endtask

  initial begin
    int n;
    bit acc;
    rst_n = 1'b0; RegWrite = 1'b0; MemToReg = 1'b0; writeReg = '0;
    readData = '0; ALUresult = '0; mc_valid = 1'b0; mc_dest = '0; mc_data = '0;
    m_streak = 0; m_force = 0; m_rst = 1;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    @(posedge clk); #1;
    step();
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_ready", 32'(mc_ready), 32'd1);
    rst_n = 1'b1;

    // WB write, ALU then load data
    RegWrite = 1'b1; MemToReg = 1'b0; writeReg = 5; ALUresult = 23; readData = 2;
    step();
    chk("t1_we", 32'(rf_we), 32'd1);
    chk("t1_addr", 32'(rf_waddr), 32'd5);
    chk("t1_alu", rf_wdata, 32'd23);
    MemToReg = 1'b1; readData = 8;
    step();
    chk("t1_load", rf_wdata, 32'd8);
    RegWrite = 1'b0; MemToReg = 1'b0;

    // Multi-cycle result into an idle slot
    mc_valid = 1'b1; mc_dest = 9; mc_data = 32'hABCD;
    step();
    chk("t2_pending", 32'(mc_pending), 32'd1);
    chk("t2_no_same_cycle", 32'(rf_we), 32'd0);
    mc_valid = 1'b0;
    step();
    chk("t2_we", 32'(rf_we), 32'd1);
    chk("t2_addr", 32'(rf_waddr), 32'd9);
    chk("t2_data", rf_wdata, 32'hABCD);
    chk("t2_pending_clr", 32'(mc_pending), 32'd0);

    // Starvation forces a slot after LIMIT WB-won cycles
    mc_valid = 1'b1; mc_dest = 3; mc_data = 32'h33;
    RegWrite = 1'b1; writeReg = 7; ALUresult = 32'h70;
    step();
    mc_valid = 1'b0;
    n = 0;
    while (!pipe_stall && n < 20) begin step(); n++; end
    chk("t3_wb_cycles", n, LIMIT);
    chk("t3_stall", 32'(pipe_stall), 32'd1);
    step();
    chk("t3_forced_addr", 32'(rf_waddr), 32'd3);
    chk("t3_forced_data", rf_wdata, 32'h33);
    chk("t3_stall_one", 32'(pipe_stall), 32'd0);
    step();
    chk("t3_wb_kept_addr", 32'(rf_waddr), 32'd7);
    chk("t3_wb_kept_data", rf_wdata, 32'h70);

    // Fill the FIFO, back-pressure, ordered drain
    writeReg = 1; ALUresult = 32'h11;
    for (int i = 0; i < DEPTH; i++) begin
      mc_valid = 1'b1; mc_dest = AW'(10 + i); mc_data = 32'h100 + i;
      step();
    end
    chk("t4_full", 32'(mc_ready), 32'd0);
    mc_dest = 20; mc_data = 32'h200;
    n = 0;
    acc = 0;
    while (n < 20) begin
      acc = mc_ready;
      step();
      if (acc) break;
      n++;
    end
    chk("t4_backpressure", 32'(n > 0), 32'd1);
    chk("t4_accepted", 32'(acc), 32'd1);
    mc_valid = 1'b0; RegWrite = 1'b0;
    n = 0;
    while (mc_pending && n < 30) begin step(); n++; end
    chk("t4_drained", 32'(mc_pending), 32'd0);

    // Writes to $0
    RegWrite = 1'b1; writeReg = 0; ALUresult = 5;
    step();
    chk("t5_wb_zero", 32'(rf_we), 32'd0);
    RegWrite = 1'b0;
    mc_valid = 1'b1; mc_dest = 0; mc_data = 32'h55;
    step();
    mc_valid = 1'b0;
    step();
    chk("t5_mc_zero", 32'(rf_we), 32'd0);
    chk("t5_popped", 32'(mc_pending), 32'd0);

    // Reset with three queued entries while in the forced slot
    RegWrite = 1'b1; writeReg = 2; ALUresult = 32'h22;
    for (int i = 0; i < 3; i++) begin
      mc_valid = 1'b1; mc_dest = AW'(24 + i); mc_data = 32'h300 + i;
      step();
    end
    mc_valid = 1'b0;
    n = 0;
    while (!pipe_stall && n < 20) begin step(); n++; end
    chk("t6_in_force", 32'(pipe_stall), 32'd1);
    rst_n = 1'b0;
    step();
    chk("t6_we", 32'(rf_we), 32'd0);
    chk("t6_addr", 32'(rf_waddr), 32'd0);
    chk("t6_data", rf_wdata, 32'd0);
    chk("t6_stall", 32'(pipe_stall), 32'd0);
    chk("t6_ready", 32'(mc_ready), 32'd1);
    chk("t6_pending", 32'(mc_pending), 32'd0);
    rst_n = 1'b1; RegWrite = 1'b0;

    // Randomized traffic; the pipeline re-presents its inputs while stalled
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      if (!pipe_stall) begin
        RegWrite  = ($urandom_range(0, 9) < 7);
        MemToReg  = $urandom_range(0, 1);
        writeReg  = AW'($urandom_range(0, 31));
        readData  = $urandom;
        ALUresult = $urandom;
      end
      mc_valid = ($urandom_range(0, 2) == 0);
      mc_dest  = AW'($urandom_range(0, 31));
      mc_data  = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters: the in-order pipeline WB stage, and a multi-cycle unit (mult/div) that returns results out of band.
- The WB-stage result has priority. Multi-cycle results queue in a small FIFO and drain into idle WB slots.
- A starvation counter forces a one-cycle pipeline stall so that a queued result is guaranteed to retire.
- Sits between MEM/WB and the register file and absorbs the MemToReg select.

Parameters:
- DEPTH, 4, multi-cycle result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 8, consecutive WB-occupied cycles with FIFO non-empty before a forced slot.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- RegWrite  in  1  WB stage requests a write this cycle.
- MemToReg  in  1  1 = write readData, 0 = write ALUresult.
- writeReg  in  AW  WB destination register.
- readData  in  DW  load data from MEM/WB.
- ALUresult  in  DW  ALU result from MEM/WB.
- pipe_stall  out  1  pipeline must freeze MEM/WB and re-present its inputs next cycle.
- mc_valid  in  1  multi-cycle unit offers a result.
- mc_ready  out  1  FIFO can accept; transfer occurs when mc_valid && mc_ready.
- mc_dest  in  AW  multi-cycle destination.
- mc_data  in  DW  multi-cycle result.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  AW  write address (registered).
- rf_wdata  out  DW  write data (registered).
- mc_pending  out  1  FIFO non-empty; used by the hazard unit.

Behaviour:
- Reset (rst_n=0 at a clk edge): rf_we=0, rf_waddr=0, rf_wdata=0, FIFO count=0, starve counter=0, state=IDLE. Consequently pipe_stall=0, mc_ready=1, mc_pending=0. Reset mid-operation discards queued entries.
- States:
  - IDLE: FIFO empty.
  - DRAIN: FIFO non-empty.
  - FORCE: one-cycle forced slot.
- pipe_stall = (state==FORCE). It is decoded from registered state only, with no combinational path from inputs.
- Port grant, evaluated each cycle:
  - If state==FORCE: the FIFO head wins. The WB inputs are ignored that cycle, and the pipeline re-presents them.
  - Else if RegWrite=1: WB wins. Data = MemToReg ? readData : ALUresult; address = writeReg.
  - Else if the FIFO is non-empty: the FIFO head wins and is popped.
  - Else: no write.
- Output latency: the granted write appears on rf_we/rf_waddr/rf_wdata exactly 1 cycle after grant. The outputs hold for one cycle only.
- Register $0: any grant with address 0 produces rf_we=0. It still consumes the slot, and a FIFO entry to $0 is still popped.
- Starve counter:
  - Clears when the FIFO pops or when the FIFO is empty.
  - Increments in DRAIN when WB wins.
  - Saturates at STARVE_LIMIT.
- Transitions:
  - IDLE→DRAIN when a push happens.
  - DRAIN→FORCE on the cycle the counter reaches STARVE_LIMIT.
  - FORCE→DRAIN if entries remain after the pop; otherwise FORCE→IDLE.
  - DRAIN→IDLE when the last entry pops with no simultaneous push.
- FIFO:
  - mc_ready = (count < DEPTH), from the registered count.
  - When full, a same-cycle pop does not enable a push.
  - Push and pop in the same cycle are legal when not full; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Pushing into an empty FIFO does not allow same-cycle drain: the entry is first eligible the next cycle.
- Ordering: FIFO entries retire in push order. No WB write is ever dropped.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- When defined, adds three 32-bit output ports:
  - perf_force_cnt: count of FORCE cycles.
  - perf_mc_full_cnt: cycles with mc_valid && !mc_ready.
  - perf_wb_cnt: writes with rf_we=1.
- The counters reset to 0 on rst_n=0 and wrap on overflow.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package wb_pkg: state encoding (IDLE=2'd0, DRAIN=2'd1, FORCE=2'd2), AW/DW defaults, and a localparam for REG_ZERO=0.
- One sub-module: wb_mc_fifo. It is a synchronous DEPTH×(AW+DW) FIFO with push/pop/full/empty/count; the arbiter FSM and grant logic stay in the top level.

Test Plan:
1. Reset, then RegWrite=1, MemToReg=0, writeReg=5, ALUresult=23, readData=2 → next cycle rf_we=1, rf_waddr=5, rf_wdata=23. Repeat with MemToReg=1, readData=8 → rf_wdata=8.
2. Push mc_dest=9, mc_data=0xABCD while RegWrite=0 → mc_pending=1. One cycle later the entry is granted; the next cycle shows rf_we=1, rf_waddr=9, rf_wdata=0xABCD, and mc_pending returns to 0.
3. Push 1 entry, then hold RegWrite=1 continuously → after 8 WB-won cycles pipe_stall=1 for exactly one cycle and the FIFO entry is written. The held WB write appears on the following grant, with no loss.
4. Push 4 entries with RegWrite=1 held → mc_ready=0 after the 4th. A 5th mc_valid is not accepted until a pop. Retirement order matches push order.
5. Writes to $0 from either source → rf_we stays 0, and the FIFO entry to $0 still pops.
6. Assert rst_n=0 with 3 entries queued and state=FORCE → next cycle all outputs are 0, pipe_stall=0, mc_ready=1, mc_pending=0.
